// File: rtl/sn74ls193_pkg.sv
// Shared constants and the per-sample operation decode for the 74LS193 model.
package sn74ls193_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;
    localparam logic [CNT_W-1:0] CNT_MIN = 4'h0;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } op_e;

    // Load wins outright. A count needs its own rising edge, the other count
    // input parked high, and no edge on the other input in the same sample.
    function automatic op_e select_op(input logic load_n,
                                      input logic up_rise,
                                      input logic dn_rise,
                                      input logic up_lvl,
                                      input logic dn_lvl);
        if (!load_n)
            return OP_LOAD;
        if (up_rise && !dn_rise && dn_lvl)
            return OP_UP;
        if (dn_rise && !up_rise && up_lvl)
            return OP_DOWN;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/sn74ls193_if.sv
// Pin bundle of one 74LS193 (everything except the sample clock and CLR).
interface sn74ls193_if;
    logic p5;   // UP
    logic p4;   // DOWN
    logic p11;  // /LOAD
    logic p15;  // A
    logic p1;   // B
    logic p10;  // C
    logic p9;   // D
    logic p3;   // QA
    logic p2;   // QB
    logic p6;   // QC
    logic p7;   // QD
    logic p12;  // /CO
    logic p13;  // /BO

    modport slave (
        input  p5, p4, p11, p15, p1, p10, p9,
        output p3, p2, p6, p7, p12, p13
    );

    modport master (
        output p5, p4, p11, p15, p1, p10, p9,
        input  p3, p2, p6, p7, p12, p13
    );
endinterface

// File: rtl/sn74ls193_edge.sv
// Registered rising-edge detector for a count input sampled on clk.
module sn74ls193_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    // Remember last sample; reset value chosen so an idle-high input gives no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prev_q <= RST_VAL;
        else
            prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/sn74ls193.sv
// 74LS193 up/down counter modelled on a single sample clock so that
// count inputs are data and stages cascade deterministically.
module sn74ls193
    import sn74ls193_pkg::*;
#(
    parameter int   CHECK    = 1,
    parameter logic PREV_RST = 1'b1
) (
    input  logic         clk,
    input  logic         p14,
    sn74ls193_if.slave   bus
);

    logic             up_rise;
    logic             dn_rise;
    op_e              op;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    sn74ls193_edge #(.RST_VAL(PREV_RST)) u_up_edge (
        .clk    (clk),
        .rst    (p14),
        .d_i    (bus.p5),
        .rise_o (up_rise)
    );

    sn74ls193_edge #(.RST_VAL(PREV_RST)) u_dn_edge (
        .clk    (clk),
        .rst    (p14),
        .d_i    (bus.p4),
        .rise_o (dn_rise)
    );

    // Decode this sample's operation and the next count.
    always_comb begin
        count_d = count_q;
        op      = select_op(bus.p11, up_rise, dn_rise, bus.p5, bus.p4);
        unique case (op)
            OP_LOAD: count_d = {bus.p9, bus.p10, bus.p1, bus.p15};
            OP_UP:   count_d = count_q + 4'd1;
            OP_DOWN: count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    // Count register; CLR clears it without waiting for a clock.
    always_ff @(posedge clk or posedge p14) begin
        if (p14)
            count_q <= CNT_MIN;
        else
            count_q <= count_d;
    end

    assign {bus.p7, bus.p6, bus.p2, bus.p3} = count_q;

    // Carry/borrow are combinational so the next stage sees them in the same sample.
    assign bus.p12 = ~((count_q == CNT_MAX) & ~bus.p5);
    assign bus.p13 = ~((count_q == CNT_MIN) & ~bus.p4);

`ifndef SYNTHESIS
    // Flag count-input combinations that the part cannot resolve.
    always @(posedge clk) begin
        if (CHECK != 0 && !p14 && bus.p11 &&
            ((up_rise && !bus.p4) || (dn_rise && !bus.p5) || (up_rise && dn_rise)))
            $display("sn74ls193 warning: illegal count input combination at %0t", $time);
    end
`endif

endmodule

// File: tb/tb_sn74ls193.sv
// Directed bench for the 74LS193 model: single part plus a two-stage cascade.
module tb_sn74ls193;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    sn74ls193_if u_if ();
    sn74ls193_if c0 ();
    sn74ls193_if c1 ();

    sn74ls193 #(.CHECK(1), .PREV_RST(1'b1)) dut (
        .clk (clk),
        .p14 (rst),
        .bus (u_if.slave)
    );

    sn74ls193 #(.CHECK(1), .PREV_RST(1'b1)) dut_lo (
        .clk (clk),
        .p14 (rst),
        .bus (c0.slave)
    );

    sn74ls193 #(.CHECK(1), .PREV_RST(1'b1)) dut_hi (
        .clk (clk),
        .p14 (rst),
        .bus (c1.slave)
    );

    assign c1.p5 = c0.p12;
    assign c1.p4 = c0.p13;

    logic [3:0] q;
    logic [7:0] qc;
    assign q  = {u_if.p7, u_if.p6, u_if.p2, u_if.p3};
    assign qc = {c1.p7, c1.p6, c1.p2, c1.p3, c0.p7, c0.p6, c0.p2, c0.p3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [3:0] v);
        {u_if.p9, u_if.p10, u_if.p1, u_if.p15} = v;
    endtask

    task automatic load(input logic [3:0] v);
        set_data(v);
        u_if.p11 = 1'b0;
        tick();
        u_if.p11 = 1'b1;
    endtask

    task automatic pulse_up();
        u_if.p5 = 1'b0;
        tick(); tick();
        u_if.p5 = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_chk++; if (q !== 4'h0) begin n_fail++; $display("FAIL reset_q got %h want 0", q); end
        n_chk++; if (u_if.p12 !== 1'b1) begin n_fail++; $display("FAIL reset_co got %b want 1", u_if.p12); end
        n_chk++; if (u_if.p13 !== 1'b1) begin n_fail++; $display("FAIL reset_bo got %b want 1", u_if.p13); end
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        n_chk++; if (q !== 4'h0) begin n_fail++; $display("FAIL release_q got %h want 0", q); end
    endtask

    task automatic test_count_down();
        logic [3:0] exp_q [3];
        exp_q[0] = 4'hF; exp_q[1] = 4'hE; exp_q[2] = 4'hD;
        for (int i = 0; i < 3; i++) begin
            u_if.p4 = 1'b0;
            #1;
            n_chk++;
            if (u_if.p13 !== ((i == 0) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL down_bo_low[%0d] got %b want %b", i, u_if.p13, (i == 0) ? 1'b0 : 1'b1);
            end
            tick(); tick();
            u_if.p4 = 1'b1;
            tick();
            n_chk++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL down_q[%0d] got %h want %h", i, q, exp_q[i]); end
            n_chk++; if (u_if.p13 !== 1'b1) begin n_fail++; $display("FAIL down_bo_high[%0d] got %b want 1", i, u_if.p13); end
            tick();
        end
    endtask

    task automatic test_up_wrap();
        load(4'hE);
        n_chk++; if (q !== 4'hE) begin n_fail++; $display("FAIL wrap_load got %h want e", q); end
        pulse_up();
        n_chk++; if (q !== 4'hF) begin n_fail++; $display("FAIL wrap_f got %h want f", q); end
        n_chk++; if (u_if.p12 !== 1'b1) begin n_fail++; $display("FAIL wrap_co_uphigh got %b want 1", u_if.p12); end
        u_if.p5 = 1'b0;
        #1;
        n_chk++; if (u_if.p12 !== 1'b0) begin n_fail++; $display("FAIL wrap_co_low got %b want 0", u_if.p12); end
        tick(); tick();
        u_if.p5 = 1'b1;
        #1;
        n_chk++; if (u_if.p12 !== 1'b1) begin n_fail++; $display("FAIL wrap_co_comb got %b want 1", u_if.p12); end
        tick();
        n_chk++; if (q !== 4'h0) begin n_fail++; $display("FAIL wrap_zero got %h want 0", q); end
        n_chk++; if (u_if.p12 !== 1'b1) begin n_fail++; $display("FAIL wrap_co_after got %b want 1", u_if.p12); end
    endtask

    task automatic test_load_priority();
        set_data(4'h5);
        u_if.p11 = 1'b0;
        tick();
        pulse_up();
        tick();
        n_chk++; if (q !== 4'h5) begin n_fail++; $display("FAIL loadpri_hold got %h want 5", q); end
        u_if.p11 = 1'b1;
        tick();
        n_chk++; if (q !== 4'h5) begin n_fail++; $display("FAIL loadpri_release got %h want 5", q); end
        pulse_up();
        n_chk++; if (q !== 4'h6) begin n_fail++; $display("FAIL loadpri_inc got %h want 6", q); end
    endtask

    task automatic test_async_clear();
        load(4'h9);
        tick();
        n_chk++; if (q !== 4'h9) begin n_fail++; $display("FAIL clr_pre got %h want 9", q); end
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (q !== 4'h0) begin n_fail++; $display("FAIL clr_async got %h want 0", q); end
        #1;
        rst = 1'b0;
        tick(); tick();
        n_chk++; if (q !== 4'h0) begin n_fail++; $display("FAIL clr_release got %h want 0", q); end
    endtask

    task automatic test_illegal();
        load(4'h7);
        u_if.p4 = 1'b0;
        tick(); tick();
        pulse_up();
        tick();
        n_chk++; if (q !== 4'h7) begin n_fail++; $display("FAIL illegal_up_dnlow got %h want 7", q); end
        set_data(4'h7);
        u_if.p11 = 1'b0;
        u_if.p4  = 1'b1;
        tick();
        u_if.p11 = 1'b1;
        tick();
        n_chk++; if (q !== 4'h7) begin n_fail++; $display("FAIL illegal_restore got %h want 7", q); end
        u_if.p4 = 1'b0;
        u_if.p5 = 1'b0;
        tick(); tick();
        u_if.p4 = 1'b1;
        u_if.p5 = 1'b1;
        tick(); tick();
        n_chk++; if (q !== 4'h7) begin n_fail++; $display("FAIL illegal_simul got %h want 7", q); end
    endtask

    task automatic test_cascade();
        {c0.p9, c0.p10, c0.p1, c0.p15} = 4'hF;
        {c1.p9, c1.p10, c1.p1, c1.p15} = 4'h0;
        c0.p11 = 1'b0;
        c1.p11 = 1'b0;
        tick();
        c0.p11 = 1'b1;
        c1.p11 = 1'b1;
        tick();
        n_chk++; if (qc !== 8'h0F) begin n_fail++; $display("FAIL casc_load got %h want 0f", qc); end
        n_chk++; if (c1.p13 !== 1'b1) begin n_fail++; $display("FAIL casc_bo_0f got %b want 1", c1.p13); end
        c0.p5 = 1'b0;
        tick(); tick();
        c0.p5 = 1'b1;
        tick();
        n_chk++; if (qc !== 8'h10) begin n_fail++; $display("FAIL casc_up got %h want 10", qc); end
        tick();
        c0.p4 = 1'b0;
        #1;
        n_chk++; if (c1.p13 !== 1'b1) begin n_fail++; $display("FAIL casc_bo_10 got %b want 1", c1.p13); end
        tick(); tick();
        c0.p4 = 1'b1;
        tick();
        n_chk++; if (qc !== 8'h0F) begin n_fail++; $display("FAIL casc_down got %h want 0f", qc); end
        n_chk++; if (c1.p13 !== 1'b1) begin n_fail++; $display("FAIL casc_bo_back got %b want 1", c1.p13); end
        {c0.p9, c0.p10, c0.p1, c0.p15} = 4'h0;
        c0.p11 = 1'b0;
        c1.p11 = 1'b0;
        tick();
        c0.p11 = 1'b1;
        c1.p11 = 1'b1;
        tick();
        n_chk++; if (qc !== 8'h00) begin n_fail++; $display("FAIL casc_zero got %h want 00", qc); end
        n_chk++; if (c1.p13 !== 1'b1) begin n_fail++; $display("FAIL casc_bo_00_high got %b want 1", c1.p13); end
        c0.p4 = 1'b0;
        #1;
        n_chk++; if (c1.p13 !== 1'b0) begin n_fail++; $display("FAIL casc_bo_00_low got %b want 0", c1.p13); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        u_if.p5 = 1'b1; u_if.p4 = 1'b1; u_if.p11 = 1'b1;
        set_data(4'h0);
        c0.p5 = 1'b1; c0.p4 = 1'b1; c0.p11 = 1'b1;
        {c0.p9, c0.p10, c0.p1, c0.p15} = 4'h0;
        c1.p11 = 1'b1;
        {c1.p9, c1.p10, c1.p1, c1.p15} = 4'h0;

        test_reset();
        test_count_down();
        test_up_wrap();
        test_load_priority();
        test_async_clear();
        test_illegal();
        test_cascade();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
